// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver.
// Shows three latched 14-bit display words (two active-low patterns each) one
// digit at a time on a shared segment bus. Each digit slot starts with a short
// blanking gap to suppress ghosting. All three words are snapshotted once per
// frame so a mid-frame CPU write never tears the display.

module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [13:0] output1,
    input  logic [13:0] output2,
    input  logic [13:0] output3,
    output logic [6:0]  seg_n,
    output logic [5:0]  an_n,
    output logic        frame_done
);

    // Slot counter is wide enough for the largest legal REFRESH_DIV (2^20-1).
    localparam int unsigned CntW = 20;

    localparam logic [CntW-1:0] LastCnt  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);
    localparam logic [2:0]      LastIdx  = 3'd5;

    localparam logic [6:0]  SegOff  = 7'h7F;
    localparam logic [5:0]  AnOff   = 6'h3F;
    localparam logic [41:0] SnapOne = '1;

    typedef enum logic {
        PhBlank,
        PhShow
    } phase_e;

    // Scan position: idx_q/cnt_q describe the cycle the next edge will begin.
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    phase_e          phase_q, phase_d;

    // Frame snapshot of {output3, output2, output1}.
    logic [41:0] snap_q, snap_d;

    // Set while digit 5's last show cycle is on the bus; turns into frame_done.
    logic last_show_q, last_show_d;

    // Registered outputs.
    logic [6:0] seg_q, seg_d;
    logic [5:0] an_q, an_d;
    logic       fd_q, fd_d;

    logic [6:0] digit_pat;

    // Select the snapshot pattern for the digit currently being scanned.
    always_comb begin
        digit_pat = SegOff;
        unique case (idx_q)
            3'd0:    digit_pat = snap_q[6:0];
            3'd1:    digit_pat = snap_q[13:7];
            3'd2:    digit_pat = snap_q[20:14];
            3'd3:    digit_pat = snap_q[27:21];
            3'd4:    digit_pat = snap_q[34:28];
            3'd5:    digit_pat = snap_q[41:35];
            default: digit_pat = SegOff;
        endcase
    end

    // Next-state and output decode for the blank/show slot sequencer.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        snap_d      = snap_q;
        last_show_d = 1'b0;
        seg_d       = SegOff;
        an_d        = AnOff;
        fd_d        = 1'b0;

        if (!scan_en) begin
            // Dark and frozen: the current digit restarts with a full blank later.
            cnt_d   = '0;
            phase_d = PhBlank;
        end else begin
            fd_d = last_show_q;

            if (cnt_q < BlankCnt) begin
                phase_d = PhBlank;
            end else begin
                phase_d = PhShow;
            end

            // First blank cycle of digit 0 opens a new frame.
            if (idx_q == 3'd0 && cnt_q == '0) begin
                snap_d = {output3, output2, output1};
            end

            // Show cycles always have cnt >= 1, so snap_q is already this frame's.
            if (phase_d == PhShow) begin
                an_d  = ~(6'b000001 << idx_q);
                seg_d = digit_pat;
            end

            if (cnt_q == LastCnt) begin
                cnt_d       = '0;
                last_show_d = (idx_q == LastIdx);
                if (idx_q == LastIdx) begin
                    idx_d = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            phase_q     <= PhBlank;
            snap_q      <= SnapOne;
            last_show_q <= 1'b0;
            seg_q       <= SegOff;
            an_q        <= AnOff;
            fd_q        <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            last_show_q <= last_show_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// A table of hand-computed cycle vectors plus directed multi-cycle sequences.

module tb_seg_scan_driver;

    logic        clock;
    logic        reset;
    logic        scan_en;
    logic [13:0] output1;
    logic [13:0] output2;
    logic [13:0] output3;
    logic [6:0]  seg_n;
    logic [5:0]  an_n;
    logic        frame_done;

    int n_tests;
    int n_fail;
    int cyc;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [6:0] seg;
        logic       fd;
    } vec_t;

    vec_t tbl[18];

    seg_scan_driver #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .scan_en   (scan_en),
        .output1   (output1),
        .output2   (output2),
        .output3   (output3),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance into the next cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [5:0] an, input logic [6:0] seg,
                             input logic fd);
        check({name, " an_n"}, 16'(an_n), 16'(an));
        check({name, " seg_n"}, 16'(seg_n), 16'(seg));
        check({name, " frame_done"}, 16'(frame_done), 16'(fd));
    endtask

    // Hold reset for n edges, then release with the given inputs (cyc becomes 0).
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_out("reset", 6'h3F, 7'h7F, 1'b0);
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    int         last_digit;
    int         blank_run;
    int         d;
    logic       exp_fd;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        tbl[0]  = '{1,  6'h3F, 7'h7F, 1'b0};
        tbl[1]  = '{2,  6'h3F, 7'h7F, 1'b0};
        tbl[2]  = '{3,  6'h3E, 7'h01, 1'b0};
        tbl[3]  = '{8,  6'h3E, 7'h01, 1'b0};
        tbl[4]  = '{9,  6'h3F, 7'h7F, 1'b0};
        tbl[5]  = '{11, 6'h3D, 7'h00, 1'b0};
        tbl[6]  = '{16, 6'h3D, 7'h00, 1'b0};
        tbl[7]  = '{19, 6'h3B, 7'h02, 1'b0};
        tbl[8]  = '{24, 6'h3B, 7'h02, 1'b0};
        tbl[9]  = '{27, 6'h37, 7'h00, 1'b0};
        tbl[10] = '{35, 6'h2F, 7'h03, 1'b0};
        tbl[11] = '{43, 6'h1F, 7'h00, 1'b0};
        tbl[12] = '{48, 6'h1F, 7'h00, 1'b0};
        tbl[13] = '{49, 6'h3F, 7'h7F, 1'b1};
        tbl[14] = '{50, 6'h3F, 7'h7F, 1'b0};
        tbl[15] = '{51, 6'h3E, 7'h40, 1'b0};
        tbl[16] = '{56, 6'h3E, 7'h40, 1'b0};
        tbl[17] = '{59, 6'h3D, 7'h7E, 1'b0};

        // ---- Reset with random inputs, scan_en high ----
        scan_en = 1'b1;
        output1 = 14'($urandom);
        output2 = 14'($urandom);
        output3 = 14'($urandom);
        reset   = 1'b1;
        do_reset(3);
        output1 = 14'h0001;
        output2 = 14'h0002;
        output3 = 14'h0003;

        // ---- Scan order, tearing, blank-gap scoreboard over 3 frames ----
        last_digit = -1;
        blank_run  = 0;
        for (int c = 1; c <= 144; c++) begin
            tick();
            for (int k = 0; k < 18; k++) begin
                if (tbl[k].cyc == cyc) begin
                    check_out($sformatf("vec%0d", k), tbl[k].an, tbl[k].seg, tbl[k].fd);
                end
            end
            exp_fd = (cyc > 1) && ((cyc - 1) % 48 == 0);
            check("frame_done timing", 16'(frame_done), 16'(exp_fd));
            check("an_n one-hot", 16'($countones(~an_n) > 1), 16'd0);
            if (an_n == 6'h3F) begin
                check("blank seg_n", 16'(seg_n), 16'h7F);
                blank_run++;
            end else begin
                d = 0;
                for (int b = 0; b < 6; b++) begin
                    if (!an_n[b]) d = b;
                end
                if (d != last_digit) begin
                    check("gap length", 16'(blank_run), 16'd2);
                    check("digit order", 16'(d), 16'((last_digit + 1) % 6));
                    last_digit = d;
                end
                blank_run = 0;
            end
            if (cyc == 20) output1 = 14'h3F40;
        end

        // ---- scan_en drop during digit 1's show phase ----
        output1 = 14'h0001;
        do_reset(1);
        for (int c = 1; c <= 12; c++) tick();
        tick();  // cycle 13: digit 1 shown
        check_out("pre-drop", 6'h3D, 7'h00, 1'b0);
        scan_en = 1'b0;
        for (int c = 14; c <= 18; c++) begin
            tick();
            check_out("scan_en low", 6'h3F, 7'h7F, 1'b0);
        end
        scan_en = 1'b1;
        for (int c = 19; c <= 30; c++) begin
            tick();
            if (cyc <= 20 || (cyc >= 27 && cyc <= 28)) begin
                check_out("re-enable blank", 6'h3F, 7'h7F, 1'b0);
            end else if (cyc <= 26) begin
                check_out("re-enable digit1", 6'h3D, 7'h00, 1'b0);
            end else begin
                check_out("re-enable digit2", 6'h3B, 7'h02, 1'b0);
            end
        end

        // ---- Mid-frame reset in cycle 30, then fresh snapshot ----
        do_reset(1);
        for (int c = 1; c <= 30; c++) tick();
        reset = 1'b1;
        tick();
        check_out("mid-frame reset", 6'h3F, 7'h7F, 1'b0);
        reset   = 1'b0;
        output1 = 14'h1234;
        cyc     = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (cyc <= 2 || cyc == 9 || cyc == 10) begin
                check_out("post-reset blank", 6'h3F, 7'h7F, 1'b0);
            end else if (cyc <= 8) begin
                check_out("post-reset digit0", 6'h3E, 7'h34, 1'b0);
            end else begin
                check_out("post-reset digit1", 6'h3D, 7'h24, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
